display_scanner: RTL and testbench

- Consumer end of the CPU's 16-bit `display_out` memory-mapped display port.
- Samples that value on the pipeline's `clk_enable` strobe and shows it as four hex digits on a multiplexed common-anode 7-segment display.
- Double-buffered, so a digit never changes mid-frame. Inter-digit blanking suppresses ghosting.
- Sits beside `cpu` at board top level.

---
 rtl/display_pkg.sv | 20 ++
 rtl/hex_to_seg7.sv | 11 +
 rtl/display_scanner.sv | 105 ++++++++++
 tb/tb_display_scanner.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package display_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    localparam logic [6:0] SEG_OFF = 7'b0000000;
    localparam logic [3:0] AN_OFF  = 4'b0000;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-high 7-segment pattern decoder.
module hex_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = SEG_TABLE[nibble];

endmodule

// File: rtl/display_scanner.sv
// Double-buffered 4-digit multiplexed common-anode hex display scanner.
// Optional leading-zero blanking is enabled by defining DISPLAY_LZ_BLANK_EN.
module display_scanner
    import display_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_enable,
    input  logic [15:0] display_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  CNT_SHOW = CW'(BLANK_CYCLES);
    localparam logic [6:0]     SEG_INV  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]     AN_INV   = AN_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [15:0]   pending_reg;
    logic [15:0]   shadow_reg;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    digit_reg, digit_next;
    scan_state_t   state_reg, state_next;
    logic [6:0]    seg_reg, seg_next;
    logic [3:0]    an_reg, an_next;
    logic          cnt_wrap;
    logic          frame_last;
    logic [3:0]    digit_lit;
    logic [6:0]    digit_pattern;

    assign cnt_wrap   = (cnt_reg == CNT_LAST);
    assign frame_last = cnt_wrap && (digit_reg == 2'd3);

    hex_to_seg7 u_hex_to_seg7 (
        .nibble  (shadow_reg[4*digit_reg +: 4]),
        .pattern (digit_pattern)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lit
`ifdef DISPLAY_LZ_BLANK_EN
            if (gi == 0) begin : g_units
                assign digit_lit[gi] = 1'b1;
            end else begin : g_upper
                // Lit only if this nibble or any more significant one is nonzero
                assign digit_lit[gi] = |shadow_reg[15:4*gi];
            end
`else
            assign digit_lit[gi] = 1'b1;
`endif
        end
    endgenerate

    always_comb begin
        cnt_next   = cnt_wrap ? '0 : cnt_reg + 1'b1;
        digit_next = cnt_wrap ? digit_reg + 2'd1 : digit_reg;
        state_next = (cnt_next >= CNT_SHOW) ? SHOW : BLANK;
        seg_next   = SEG_OFF;
        an_next    = AN_OFF;
        if (state_reg == SHOW && digit_lit[digit_reg]) begin
            seg_next = digit_pattern;
            an_next  = 4'b0001 << digit_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
            shadow_reg  <= '0;
            cnt_reg     <= '0;
            digit_reg   <= '0;
            state_reg   <= BLANK;
            seg_reg     <= SEG_OFF ^ SEG_INV;
            an_reg      <= AN_OFF ^ AN_INV;
        end else begin
            if (clk_enable) begin
                pending_reg <= display_in;
            end
            // Loads the pre-capture pending value when both happen together
            if (frame_last) begin
                shadow_reg <= pending_reg;
            end
            cnt_reg   <= cnt_next;
            digit_reg <= digit_next;
            state_reg <= state_next;
            seg_reg   <= seg_next ^ SEG_INV;
            an_reg    <= an_next ^ AN_INV;
        end
    end

    assign seg        = seg_reg;
    assign an         = an_reg;
    assign dp         = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
    assign frame_done = frame_last;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner with an 8-cycle slot and 2 blank cycles.
module tb_display_scanner;

    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_enable = 1'b0;
    logic [15:0] display_in = 16'h0000;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    always #5 clk = ~clk;

    display_scanner #(
        .REFRESH_DIV    (RD),
        .BLANK_CYCLES   (BC),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_enable (clk_enable),
        .display_in (display_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       chk_seg;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          m_pos = 0;
    logic [15:0] m_pend = 16'h0000;
    logic [15:0] m_shadow = 16'h0000;

    function automatic logic [6:0] seg_lo(input logic [3:0] n);
        logic [6:0] t;
        case (n)
            4'h0: t = 7'b0111111;  4'h1: t = 7'b0000110;
            4'h2: t = 7'b1011011;  4'h3: t = 7'b1001111;
            4'h4: t = 7'b1100110;  4'h5: t = 7'b1101101;
            4'h6: t = 7'b1111101;  4'h7: t = 7'b0000111;
            4'h8: t = 7'b1111111;  4'h9: t = 7'b1101111;
            4'hA: t = 7'b1110111;  4'hB: t = 7'b1111100;
            4'hC: t = 7'b0111001;  4'hD: t = 7'b1011110;
            4'hE: t = 7'b1111001;  default: t = 7'b1110001;
        endcase
        return ~t;
    endfunction

    // Outputs seen just after an edge reflect frame position pos (the pre-edge position)
    function automatic exp_t predict(input int pos, input logic [15:0] shd);
        exp_t       e;
        int         c;
        int         d;
        logic [3:0] nib;
        bit         lit;
        c = pos % RD;
        d = (pos / RD) % 4;
        e.an      = 4'b1111;
        e.seg     = 7'b1111111;
        e.chk_seg = 1'b1;
        e.fd      = (((pos + 1) % FRAME) == FRAME - 1);
        nib = shd[4*d +: 4];
        lit = 1'b1;
`ifdef DISPLAY_LZ_BLANK_EN
        if (d > 0 && (shd >> (4 * d)) == 16'h0000) lit = 1'b0;
`endif
        if (c >= BC) begin
            if (lit) begin
                e.an  = ~(4'b0001 << d);
                e.seg = seg_lo(nib);
            end else begin
                e.chk_seg = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic step(input logic en, input logic [15:0] val);
        exp_t e;
        clk_enable = en;
        display_in = val;
        sb_q.push_back(predict(m_pos, m_shadow));
        if (m_pos % FRAME == FRAME - 1) m_shadow = m_pend;
        if (en) m_pend = val;
        m_pos++;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (an !== e.an) begin
            failures++;
            $display("FAIL an pos=%0d got=%b exp=%b", m_pos - 1, an, e.an);
        end
        if (e.chk_seg) begin
            checks++;
            if (seg !== e.seg) begin
                failures++;
                $display("FAIL seg pos=%0d got=%b exp=%b", m_pos - 1, seg, e.seg);
            end
        end
        checks++;
        if (frame_done !== e.fd) begin
            failures++;
            $display("FAIL frame_done pos=%0d got=%b exp=%b", m_pos, frame_done, e.fd);
        end
        checks++;
        if (dp !== 1'b1) begin
            failures++;
            $display("FAIL dp pos=%0d got=%b exp=1", m_pos, dp);
        end
        if (m_pos % RD == 0)
            $display("slot end pos=%0d shadow=%h an=%b seg=%b", m_pos - 1, m_shadow, an, seg);
    endtask

    task automatic align(input int target, input logic en, input logic [15:0] val);
        while (m_pos % FRAME != target) step(en, val);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (an !== 4'b1111) begin
            failures++;
            $display("FAIL %s_an got=%b exp=1111", tag, an);
        end
        checks++;
        if (seg !== 7'b1111111) begin
            failures++;
            $display("FAIL %s_seg got=%b exp=1111111", tag, seg);
        end
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL %s_frame_done got=%b exp=0", tag, frame_done);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        m_pos = 0;
        m_pend = 16'h0000;
        m_shadow = 16'h0000;
        sb_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        release_reset();
        for (int i = 0; i < 44; i++) step(1'b1, 16'h5A5A);
        // Mid-SHOW with 5A5A lit; reset must blank outputs without waiting for a clock
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        @(posedge clk);
        #1;
        check_reset_outputs("held");
        release_reset();
        for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 16'hFFFF);
        $display("test_reset done pos=%0d", m_pos);
    endtask

    task automatic test_pattern();
        align(0, 1'b0, 16'h1A3F);
        for (int i = 0; i < 2 * FRAME; i++) step(logic'(i % 2), 16'h1A3F);
        $display("test_pattern done pos=%0d", m_pos);
    endtask

    task automatic test_midframe();
        align(0, 1'b1, 16'h1111);
        for (int i = 0; i < FRAME + 10; i++) step(1'b1, 16'h1111);
        for (int i = 0; i < FRAME + 22; i++) step(1'b1, 16'h2222);
        $display("test_midframe done pos=%0d", m_pos);
    endtask

    task automatic test_hold();
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0000);
        for (int i = 0; i < 3 * FRAME; i++) step(1'b0, 16'hBEEF);
        $display("test_hold done pos=%0d", m_pos);
    endtask

    task automatic test_coincide();
        step(1'b1, 16'h1234);
        align(FRAME - 1, 1'b0, 16'h9999);
        step(1'b1, 16'h5678);
        for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 16'hCCCC);
        $display("test_coincide done pos=%0d", m_pos);
    endtask

    task automatic test_frame_done();
        int pulses = 0;
        int first_pos = -1;
        int last_pos = -1;
        align(0, 1'b0, 16'h0000);
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(1'b0, 16'h0000);
            if (frame_done === 1'b1) begin
                pulses++;
                if (first_pos < 0) first_pos = m_pos;
                last_pos = m_pos;
                checks++;
                if (an !== 4'b0111) begin
                    failures++;
                    $display("FAIL fd_digit3 pos=%0d got=%b exp=0111", m_pos, an);
                end
            end
        end
        checks++;
        if (pulses !== 3) begin
            failures++;
            $display("FAIL fd_count got=%0d exp=3", pulses);
        end
        checks++;
        if (last_pos - first_pos !== 2 * FRAME) begin
            failures++;
            $display("FAIL fd_period got=%0d exp=%0d", last_pos - first_pos, 2 * FRAME);
        end
        $display("test_frame_done pulses=%0d", pulses);
    endtask

    task automatic test_lz_blank();
        align(0, 1'b1, 16'h00A5);
        for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 16'h00A5);
        for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 16'h0000);
        $display("test_lz_blank done pos=%0d", m_pos);
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_midframe();
        test_hold();
        test_coincide();
        test_frame_done();
        test_lz_blank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
